// File: rtl/led_matrix_pkg.sv
// Shared polarity constants and vector helpers for the LED matrix scanner.
// Helpers return a wide vector; callers size-cast to their own COLS/ROWS.
package led_matrix_pkg;

  localparam bit ACTIVE_LOW  = 1'b1;
  localparam bit ACTIVE_HIGH = 1'b0;
  localparam int MAX_W       = 64;

  function automatic logic [MAX_W-1:0] onehot_col(input int idx, input int cols);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == idx && i < cols) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Pin level that means "off" for a vector of the given polarity.
  function automatic logic [MAX_W-1:0] idle_level(input bit active_low);
    return active_low ? {MAX_W{1'b1}} : {MAX_W{1'b0}};
  endfunction

endpackage

// File: rtl/led_scan_timebase.sv
// Phase/column counters for the scanner; publishes the state for the next cycle
// so the top can register outputs that match the counters cycle for cycle.
module led_scan_timebase #(
  parameter int COLS  = 5,
  parameter int DIV   = 50000,
  parameter int BLANK = 1,
  localparam int CW   = $clog2(COLS),
  localparam int PW   = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] col_nxt,
  output logic          slot_tick,
  output logic          frame_boundary,
  output logic          blank_phase
);

  logic [CW-1:0] col;
  logic [PW-1:0] phase;
  logic          run;
  logic [PW-1:0] phase_nxt;
  logic          run_nxt;

  // A cycle with en low, or the first cycle after en rises, parks the scan at (0,0).
  always_comb begin
    run_nxt   = en;
    col_nxt   = col;
    phase_nxt = phase;
    if (!en || !run) begin
      col_nxt   = '0;
      phase_nxt = '0;
    end else if (phase == PW'(DIV - 1)) begin
      phase_nxt = '0;
      col_nxt   = (col == CW'(COLS - 1)) ? '0 : col + 1'b1;
    end else begin
      phase_nxt = phase + 1'b1;
    end
    slot_tick      = run_nxt && (phase_nxt == '0);
    frame_boundary = (col_nxt == '0) && (phase_nxt == '0);
    blank_phase    = !run_nxt || (32'(phase_nxt) < BLANK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col   <= '0;
      phase <= '0;
      run   <= 1'b0;
    end else begin
      col   <= col_nxt;
      phase <= phase_nxt;
      run   <= run_nxt;
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered column-scanning LED matrix driver with tear-free frame swaps
// and per-slot blanking; all outputs registered from the next counter state.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int COLS           = 5,
  parameter int ROWS           = 7,
  parameter int DIV            = 50000,
  parameter int BLANK          = 1,
  parameter bit ROW_ACTIVE_LOW = ACTIVE_LOW,
  parameter bit COL_ACTIVE_LOW = ACTIVE_HIGH,
  localparam int CW            = $clog2(COLS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            wr_en,
  input  logic [CW-1:0]   wr_col,
  input  logic [ROWS-1:0] wr_data,
  input  logic            commit,
  output logic            pending,
  output logic            frame_start,
  output logic [COLS-1:0] coluna,
  output logic [ROWS-1:0] linha
);

  localparam logic [COLS-1:0] COL_IDLE = COLS'(idle_level(COL_ACTIVE_LOW));
  localparam logic [ROWS-1:0] ROW_IDLE = ROWS'(idle_level(ROW_ACTIVE_LOW));

  logic [COLS-1:0][ROWS-1:0] shadow, shadow_n;
  logic [COLS-1:0][ROWS-1:0] display, display_n;
  logic [ROWS-1:0]           slot_rows, rows_n;
  logic [COLS-1:0]           col_dec;
  logic [ROWS-1:0]           row_dec;
  logic                      pending_n;
  logic                      swap;
  logic [CW-1:0]             col_nxt;
  logic                      slot_tick;
  logic                      frame_boundary;
  logic                      blank_phase;

  led_scan_timebase #(
    .COLS  (COLS),
    .DIV   (DIV),
    .BLANK (BLANK)
  ) u_timebase (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .col_nxt        (col_nxt),
    .slot_tick      (slot_tick),
    .frame_boundary (frame_boundary),
    .blank_phase    (blank_phase)
  );

  // The swap copies the pre-write shadow, so a same-cycle write waits for the next commit.
  always_comb begin
    shadow_n = shadow;
    if (wr_en && (32'(wr_col) < COLS)) shadow_n[wr_col] = wr_data;
    swap      = frame_boundary && pending;
    display_n = swap ? shadow : display;
    pending_n = swap ? commit : (pending | commit);
    // Row bitmap is captured once per slot; the display only changes on slot starts.
    rows_n    = slot_tick ? display_n[col_nxt] : slot_rows;
    col_dec   = blank_phase ? '0 : COLS'(onehot_col(int'(col_nxt), COLS));
    row_dec   = blank_phase ? '0 : rows_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow      <= '0;
      display     <= '0;
      slot_rows   <= '0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
      coluna      <= COL_IDLE;
      linha       <= ROW_IDLE;
    end else begin
      shadow      <= shadow_n;
      display     <= display_n;
      slot_rows   <= rows_n;
      pending     <= pending_n;
      frame_start <= slot_tick && frame_boundary;
      coluna      <= col_dec ^ COL_IDLE;
      linha       <= row_dec ^ ROW_IDLE;
    end
  end

endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Parametrised column-scanning driver for the irrigation panel LED matrix. It replaces the fixed 5x7 column shifter and the hard-wired row equations with a double-buffered frame store. Client logic writes one column bitmap at a time into a shadow buffer and requests a commit. The scanner swaps buffers only at a frame boundary, so the display never tears, and it inserts blanking between columns to suppress ghosting.

## Interface
Parameters:
- COLS, 5: number of matrix columns, 2 or more.
- ROWS, 7: number of matrix rows, 1 or more.
- DIV, 50000: clock cycles per column slot, 2 or more.
- BLANK, 1: blank cycles at the start of each slot, 0 ≤ BLANK < DIV.
- ROW_ACTIVE_LOW, 1: row pins are lit when 0.
- COL_ACTIVE_LOW, 0: column pins are selected when 0.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- en  in  1  scan enable
- wr_en  in  1  write one column bitmap into the shadow buffer
- wr_col  in  CW = $clog2(COLS)  column index of the write
- wr_data  in  ROWS  bitmap for the write; bit r = 1 means row r lit
- commit  in  1  request a shadow-to-display copy
- pending  out  1  a commit is requested but not yet applied
- frame_start  out  1  one-cycle pulse marking slot 0, phase 0
- coluna  out  COLS  one-hot column select, polarity set by COL_ACTIVE_LOW
- linha  out  ROWS  row drive, polarity set by ROW_ACTIVE_LOW

## Operation
- Internal state:
  - phase counter p, range 0..DIV-1
  - column index c, range 0..COLS-1
  - shadow buffer and display buffer, each COLS x ROWS bits
  - pending flag
- Counting:
  - p increments every cycle while en = 1.
  - When p = DIV-1, p wraps to 0 and c increments.
  - c wraps from COLS-1 to 0.
- Frame boundary: the cycle in which the next state is (c = 0, p = 0).
- Output decode at state (c, p):
  - Blank when p < BLANK or en = 0: all columns and rows inactive.
  - Otherwise coluna selects column c, and row r is lit when display[c][r] = 1.
- Writes:
  - wr_en with wr_col < COLS writes wr_data into shadow[wr_col].
  - wr_col ≥ COLS is ignored.
  - Writes are accepted in every state, including while pending = 1.
- Commit:
  - commit sets pending.
  - At the frame boundary with pending = 1, display takes shadow and pending clears.
  - commit while pending = 1 is a no-op, giving a single swap.
- Simultaneous events:
  - A write in the swap cycle lands in shadow only; it is not part of the swapped frame.
  - A commit in the swap cycle sets pending again, to be applied at the next boundary.
- en = 0:
  - Counters are held at (0, 0) and outputs are blank.
  - A pending commit is applied on the next clock and pending clears.
- en rising: scanning restarts at (0, 0), and frame_start asserts on the first enabled cycle.
- Reset, including mid-scan:
  - All outputs go inactive immediately: coluna = COL_ACTIVE_LOW ? all 1 : all 0; linha = ROW_ACTIVE_LOW ? all 1 : all 0.
  - pending = 0, frame_start = 0.
  - Both buffers and both counters clear.

## Timing
- All outputs are registered and decoded from the state the counters hold in the same cycle; there are no combinational paths from inputs to outputs.
- Write-to-display latency: from the commit cycle to the next frame boundary, at most COLS*DIV cycles.
- Frame period: COLS*DIV cycles. frame_start pulses exactly once per frame.
- Each slot: BLANK blank cycles, then DIV-BLANK lit cycles.

## Structure
- Package led_matrix_pkg:
  - polarity constants
  - function onehot_col(idx, COLS)
  - function for the blank-level value of row and column vectors
- Sub-module led_scan_timebase:
  - holds the p/c counters and the en hold/clear
  - emits slot_tick, frame_boundary and blank_phase
- The top level holds the buffers, commit logic and output registers.

## Test plan
All scenarios use COLS=5, ROWS=7, DIV=4, BLANK=1 unless stated.
- Reset asserted mid-scan → same cycle coluna=5'b00000, linha=7'h7F, pending=0; after release, frame_start is first seen on the first enabled cycle.
- Write col 3 = 7'b0001111, then commit → display stays all-off until the boundary; next frame, during c=3 lit phases, coluna=5'b01000 and linha=7'b1110000.
- Free run over 3 frames → frame_start every 20 cycles; each slot shows 1 blank cycle then 3 lit cycles; column order 0,1,2,3,4,0.
- Commit issued at c=2 with new data → columns 2..4 still show old data; pending stays 1 until the boundary cycle, then drops to 0 with new data from c=0.
- Two commits in one frame, plus a write with wr_col=5 → single swap; the out-of-range write leaves shadow unchanged.
- Drop en for 10 cycles with pending=1 → outputs blank and pending clears 1 cycle later; on en=1, scanning restarts at c=0 with frame_start and shows the new data.
